// File: rtl/lsu_bus_bridge_if.sv
// Word-wide data bus with req/gnt handshake for writes and read address,
// followed by rvalid-qualified read data.
interface lsu_bus_bridge_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_gnt, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_gnt, bus_rvalid, bus_rdata
  );
endinterface

// File: rtl/lsu_bus_bridge.sv
// Load/store unit bridging the single-cycle core datapath to a wait-state bus;
// stalls the core until each access retires and extends load data.
//
// state  | meaning
// IDLE   | decode mem_rd/mem_wr, reject illegal accesses, latch legal ones
// REQ    | bus_req high, waiting for bus_gnt
// WAIT_R | read address taken, waiting for bus_rvalid
// DONE   | stall released for one cycle so the core retires the instruction
module lsu_bus_bridge #(
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_rd_i,
  input  logic               mem_wr_i,
  input  logic [2:0]         funct3_i,
  input  logic [31:0]        addr_i,
  input  logic [31:0]        wr_data_i,
  output logic [31:0]        rd_data_o,
  output logic               stall_o,
  output logic               access_err_o,
  output logic               bus_err_o,
  lsu_bus_bridge_if.master   bus
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_R, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [31:0]     addr_q, addr_d;
  logic            we_q, we_d;
  logic [3:0]      be_q, be_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [1:0]      size_q, size_d;
  logic            uns_q, uns_d;
  logic [1:0]      lo_q, lo_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     rd_data_q, rd_data_d;
  logic            berr_q, berr_d;

  logic            access;
  logic            legal;
  logic [3:0]      be_dec;
  logic [31:0]     wdata_dec;
  logic [31:0]     rshift;
  logic [31:0]     ld_val;
  logic            tmo_hit;
  logic [CW-1:0]   cnt_inc;

  assign access = mem_rd_i | mem_wr_i;

  // Unsigned sizes exist only for loads; stores with 100/101 are rejected.
  always_comb begin
    legal = 1'b0;
    case (funct3_i)
      3'b000:  legal = 1'b1;
      3'b001:  legal = ~addr_i[0];
      3'b010:  legal = (addr_i[1:0] == 2'b00);
      3'b100:  legal = ~mem_wr_i;
      3'b101:  legal = ~mem_wr_i & ~addr_i[0];
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    be_dec    = 4'b1111;
    wdata_dec = wr_data_i;
    case (funct3_i[1:0])
      2'b00: begin
        be_dec    = 4'b0001 << addr_i[1:0];
        wdata_dec = {4{wr_data_i[7:0]}};
      end
      2'b01: begin
        be_dec    = addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_dec = {2{wr_data_i[15:0]}};
      end
      default: begin
        be_dec    = 4'b1111;
        wdata_dec = wr_data_i;
      end
    endcase
  end

  // Halves are always 2-byte aligned, so one lane shift serves bytes and halves.
  assign rshift = bus.bus_rdata >> {lo_q, 3'b000};

  always_comb begin
    ld_val = bus.bus_rdata;
    case (size_q)
      2'b00:   ld_val = uns_q ? {24'h0, rshift[7:0]}  : {{24{rshift[7]}}, rshift[7:0]};
      2'b01:   ld_val = uns_q ? {16'h0, rshift[15:0]} : {{16{rshift[15]}}, rshift[15:0]};
      default: ld_val = bus.bus_rdata;
    endcase
  end

  assign tmo_hit = (TIMEOUT != 0) && (cnt_q >= CW'(TIMEOUT - 1));
  assign cnt_inc = cnt_q + CW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      we_q      <= 1'b0;
      be_q      <= '0;
      wdata_q   <= '0;
      size_q    <= '0;
      uns_q     <= 1'b0;
      lo_q      <= '0;
      cnt_q     <= '0;
      rd_data_q <= '0;
      berr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      size_q    <= size_d;
      uns_q     <= uns_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
      rd_data_q <= rd_data_d;
      berr_q    <= berr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    we_d      = we_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    size_d    = size_q;
    uns_d     = uns_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    rd_data_d = rd_data_q;
    berr_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (access && legal) begin
          addr_d  = {addr_i[31:2], 2'b00};
          we_d    = mem_wr_i;
          be_d    = be_dec;
          wdata_d = wdata_dec;
          size_d  = funct3_i[1:0];
          uns_d   = funct3_i[2];
          lo_d    = addr_i[1:0];
          cnt_d   = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        // A grant in the final allowed cycle still wins over the abort.
        if (bus.bus_gnt) begin
          state_d = we_q ? S_DONE : S_WAIT_R;
          if (TIMEOUT != 0) cnt_d = cnt_inc;
        end else if (tmo_hit) begin
          state_d = S_DONE;
          berr_d  = 1'b1;
          if (!we_q) rd_data_d = '0;
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_inc;
        end
      end
      S_WAIT_R: begin
        if (bus.bus_rvalid) begin
          rd_data_d = ld_val;
          state_d   = S_DONE;
        end else if (tmo_hit) begin
          rd_data_d = '0;
          berr_d    = 1'b1;
          state_d   = S_DONE;
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_inc;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.bus_req   = (state_q == S_REQ);
    bus.bus_we    = we_q;
    bus.bus_addr  = addr_q;
    bus.bus_be    = be_q;
    bus.bus_wdata = wdata_q;
    stall_o       = ((state_q == S_IDLE) && access && legal) ||
                    (state_q == S_REQ) || (state_q == S_WAIT_R);
    access_err_o  = (state_q == S_IDLE) && access && !legal;
    bus_err_o     = berr_q;
    rd_data_o     = rd_data_q;
  end

endmodule

// File: tb/tb_lsu_bus_bridge.sv
// Directed bench for lsu_bus_bridge (TIMEOUT=4): loads, stores, illegal
// accesses, timeout abort and asynchronous reset mid-transaction.
module tb_lsu_bus_bridge;
  logic        clk = 1'b0;
  logic        rst;
  logic        mem_rd, mem_wr;
  logic [2:0]  funct3;
  logic [31:0] addr, wr_data;
  logic [31:0] rd_data;
  logic        stall, access_err, bus_err;
  int          total = 0;
  int          bad = 0;

  lsu_bus_bridge_if bus ();

  lsu_bus_bridge #(.TIMEOUT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_rd_i     (mem_rd),
    .mem_wr_i     (mem_wr),
    .funct3_i     (funct3),
    .addr_i       (addr),
    .wr_data_i    (wr_data),
    .rd_data_o    (rd_data),
    .stall_o      (stall),
    .access_err_o (access_err),
    .bus_err_o    (bus_err),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Minimum-latency load; a stray rvalid in the grant cycle must be ignored.
  // Returns with the DUT in DONE.
  task automatic load_min(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    mem_rd = 1'b1; funct3 = f3; addr = a;
    step();
    bus.bus_gnt = 1'b1; bus.bus_rvalid = 1'b1; bus.bus_rdata = 32'hBAD0BAD0;
    step();
    bus.bus_gnt = 1'b0; bus.bus_rdata = d;
    step();
    bus.bus_rvalid = 1'b0; mem_rd = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; mem_rd = 1'b0; mem_wr = 1'b0; funct3 = 3'b000;
    addr = '0; wr_data = '0;
    bus.bus_gnt = 1'b0; bus.bus_rvalid = 1'b0; bus.bus_rdata = '0;
    #1;
    chk("rst_req", 32'(bus.bus_req), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_rd", rd_data, 32'd0);
    chk("rst_aerr", 32'(access_err), 32'd0);
    chk("rst_berr", 32'(bus_err), 32'd0);
    chk("rst_addr", bus.bus_addr, 32'd0);
    chk("rst_be", 32'(bus.bus_be), 32'd0);
    step(); step();
    rst = 1'b0;
    step();

    // LW 0x100, gnt first REQ cycle, rvalid two cycles later
    mem_rd = 1'b1; funct3 = 3'b010; addr = 32'h100;
    #1 chk("lw_c0_stall", 32'(stall), 32'd1);
    chk("lw_c0_req", 32'(bus.bus_req), 32'd0);
    step();
    bus.bus_gnt = 1'b1;
    #1 chk("lw_c1_req", 32'(bus.bus_req), 32'd1);
    chk("lw_addr", bus.bus_addr, 32'h100);
    chk("lw_be", 32'(bus.bus_be), 32'hF);
    chk("lw_we", 32'(bus.bus_we), 32'd0);
    chk("lw_c1_stall", 32'(stall), 32'd1);
    step();
    bus.bus_gnt = 1'b0;
    #1 chk("lw_c2_stall", 32'(stall), 32'd1);
    chk("lw_c2_req", 32'(bus.bus_req), 32'd0);
    step();
    bus.bus_rvalid = 1'b1; bus.bus_rdata = 32'hDEADBEEF;
    #1 chk("lw_c3_stall", 32'(stall), 32'd1);
    step();
    bus.bus_rvalid = 1'b0;
    #1 chk("lw_done_stall", 32'(stall), 32'd0);
    chk("lw_rd", rd_data, 32'hDEADBEEF);
    chk("lw_berr", 32'(bus_err), 32'd0);
    mem_rd = 1'b0;
    step();

    // timeout: gnt never comes
    mem_rd = 1'b1; funct3 = 3'b010; addr = 32'h400;
    #1 chk("to_c0_stall", 32'(stall), 32'd1);
    step();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("to_req%0d", i), 32'(bus.bus_req), 32'd1);
      chk($sformatf("to_stall%0d", i), 32'(stall), 32'd1);
      step();
    end
    chk("to_done_req", 32'(bus.bus_req), 32'd0);
    chk("to_done_berr", 32'(bus_err), 32'd1);
    chk("to_done_rd", rd_data, 32'd0);
    chk("to_done_stall", 32'(stall), 32'd0);
    mem_rd = 1'b0;
    step();
    chk("to_idle_berr", 32'(bus_err), 32'd0);
    step();
    bus.bus_gnt = 1'b1; bus.bus_rvalid = 1'b1; bus.bus_rdata = 32'h11111111;
    #1 chk("to_late_req", 32'(bus.bus_req), 32'd0);
    chk("to_late_stall", 32'(stall), 32'd0);
    step();
    chk("to_late_req2", 32'(bus.bus_req), 32'd0);
    chk("to_late_berr", 32'(bus_err), 32'd0);
    chk("to_late_rd", rd_data, 32'd0);
    bus.bus_gnt = 1'b0; bus.bus_rvalid = 1'b0;
    step();

    // sub-word loads with extension
    load_min(3'b000, 32'h103, 32'h80FF0011);
    chk("lb_rd", rd_data, 32'hFFFFFF80);
    step();
    load_min(3'b100, 32'h103, 32'h80FF0011);
    chk("lbu_rd", rd_data, 32'h00000080);
    step();
    load_min(3'b101, 32'h102, 32'h80FF0011);
    chk("lhu_rd", rd_data, 32'h000080FF);
    step();
    load_min(3'b001, 32'h102, 32'h80FF0011);
    chk("lh_rd", rd_data, 32'hFFFF80FF);
    step();
    load_min(3'b000, 32'h101, 32'h80FF0011);
    chk("lb1_rd", rd_data, 32'h00000000);
    step();
    load_min(3'b101, 32'h100, 32'h80FF9011);
    chk("lhu0_rd", rd_data, 32'h00009011);
    step();

    // SH 0x206, immediate grant
    mem_wr = 1'b1; funct3 = 3'b001; addr = 32'h206; wr_data = 32'h1234ABCD;
    #1 chk("sh_c0_stall", 32'(stall), 32'd1);
    step();
    bus.bus_gnt = 1'b1;
    #1 chk("sh_req", 32'(bus.bus_req), 32'd1);
    chk("sh_addr", bus.bus_addr, 32'h204);
    chk("sh_be", 32'(bus.bus_be), 32'hC);
    chk("sh_wdata", bus.bus_wdata, 32'hABCDABCD);
    chk("sh_we", 32'(bus.bus_we), 32'd1);
    chk("sh_c1_stall", 32'(stall), 32'd1);
    step();
    bus.bus_gnt = 1'b0;
    #1 chk("sh_done_stall", 32'(stall), 32'd0);
    chk("sh_done_req", 32'(bus.bus_req), 32'd0);
    chk("sh_rd_kept", rd_data, 32'h00009011);
    mem_wr = 1'b0;
    step();

    // SB 0x301 with one wait state: bus fields held until grant
    mem_wr = 1'b1; funct3 = 3'b000; addr = 32'h301; wr_data = 32'h000000AB;
    step();
    mem_wr = 1'b0; wr_data = 32'hFFFFFFFF;
    #1 chk("sb_w_req", 32'(bus.bus_req), 32'd1);
    chk("sb_w_be", 32'(bus.bus_be), 32'h2);
    chk("sb_w_wdata", bus.bus_wdata, 32'hABABABAB);
    step();
    bus.bus_gnt = 1'b1;
    #1 chk("sb_g_req", 32'(bus.bus_req), 32'd1);
    chk("sb_g_addr", bus.bus_addr, 32'h300);
    chk("sb_g_wdata", bus.bus_wdata, 32'hABABABAB);
    step();
    bus.bus_gnt = 1'b0;
    #1 chk("sb_done_stall", 32'(stall), 32'd0);
    step();

    // illegal / misaligned accesses
    mem_rd = 1'b1; funct3 = 3'b010; addr = 32'h1002;
    #1 chk("mis_aerr", 32'(access_err), 32'd1);
    chk("mis_stall", 32'(stall), 32'd0);
    chk("mis_req", 32'(bus.bus_req), 32'd0);
    mem_rd = 1'b0;
    step();
    chk("mis_after_req", 32'(bus.bus_req), 32'd0);
    chk("mis_after_aerr", 32'(access_err), 32'd0);
    mem_rd = 1'b1; funct3 = 3'b011; addr = 32'h1000;
    #1 chk("f011_aerr", 32'(access_err), 32'd1);
    chk("f011_stall", 32'(stall), 32'd0);
    mem_rd = 1'b0;
    step();
    chk("f011_after_req", 32'(bus.bus_req), 32'd0);
    mem_wr = 1'b1; funct3 = 3'b100; addr = 32'h1000;
    #1 chk("sbu_aerr", 32'(access_err), 32'd1);
    chk("sbu_stall", 32'(stall), 32'd0);
    mem_wr = 1'b0;
    step();
    chk("sbu_after_req", 32'(bus.bus_req), 32'd0);

    // reset while in WAIT_R, then a normal load
    mem_rd = 1'b1; funct3 = 3'b010; addr = 32'h10;
    step();
    bus.bus_gnt = 1'b1;
    step();
    bus.bus_gnt = 1'b0; mem_rd = 1'b0;
    #1 chk("wr_stall_pre", 32'(stall), 32'd1);
    rst = 1'b1;
    #1 chk("arst_req", 32'(bus.bus_req), 32'd0);
    chk("arst_stall", 32'(stall), 32'd0);
    chk("arst_rd", rd_data, 32'd0);
    chk("arst_berr", 32'(bus_err), 32'd0);
    step();
    rst = 1'b0;
    step();
    load_min(3'b010, 32'h10, 32'h5555AAAA);
    chk("post_rst_rd", rd_data, 32'h5555AAAA);
    chk("post_rst_stall", 32'(stall), 32'd0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lsu_bus_bridge.md
Name: lsu_bus_bridge

Overview:
- Load/store unit between the single-cycle core datapath and a word-wide data bus with variable wait states.
- Consumes the datapath's ALU address, store data, memory read/write strobes and funct3.
- Drives a req/gnt/rvalid bus, produces the sign/zero-extended load result, and stalls the core until the access retires.

Parameters:
TIMEOUT, 16, max cycles spent in REQ+WAIT_R before abort; 0 disables timeout; internal counter width is clog2(TIMEOUT+1).

Ports:
clk  input  1  core clock, all state on rising edge
rst  input  1  reset, asynchronous, active-high
mem_rd  input  1  load request from control unit
mem_wr  input  1  store request from control unit; wins if both mem_rd and mem_wr are asserted
funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
addr  input  32  byte address (ALU result)
wr_data  input  32  store data (rs2), unaligned LSB-justified
rd_data  output  32  extended load result, registered
stall  output  1  freeze PC/regfile write while high
access_err  output  1  one-cycle pulse: misaligned or illegal funct3
bus_err  output  1  one-cycle pulse: timeout abort
bus_req  output  1  bus request
bus_we  output  1  1 = write
bus_addr  output  32  word address, {addr[31:2],2'b00}
bus_be  output  4  byte enables
bus_wdata  output  32  lane-replicated store data
bus_gnt  input  1  request accepted (write complete / read address taken)
bus_rvalid  input  1  read data valid
bus_rdata  input  32  read data word

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0, including rd_data and the timeout counter.
- States: IDLE, REQ, WAIT_R, DONE.
- IDLE, access present (mem_rd|mem_wr):
  - Legality: H needs addr[0]=0; W needs addr[1:0]=0; funct3 011/110/111 illegal; stores also illegal for 100/101.
  - Illegal or misaligned: access_err=1 for this cycle, stall=0, no bus activity, stay IDLE.
  - Legal: latch bus_addr/bus_we/bus_be/bus_wdata plus size/sign/addr[1:0]; go REQ.
  - stall is combinational and =1 in this cycle.
- Byte enables and store data:
  - SB: bus_be = 4'b0001<<addr[1:0], bus_wdata = {4{wr_data[7:0]}}.
  - SH: bus_be = addr[1] ? 1100 : 0011, bus_wdata = {2{wr_data[15:0]}}.
  - SW: bus_be = 1111, bus_wdata = wr_data.
  - Loads drive the same byte-enable pattern.
- REQ:
  - bus_req=1; addr/we/be/wdata held stable until bus_gnt.
  - On gnt: write → DONE; read → WAIT_R.
  - bus_rvalid is ignored in REQ.
- WAIT_R:
  - bus_req=0. On bus_rvalid, select the byte/half by latched addr[1:0], sign-extend (B/H) or zero-extend (BU/HU), register into rd_data, go DONE.
  - rvalid in the same cycle as gnt is not accepted; the earliest is the cycle after gnt.
- DONE:
  - stall=0 for exactly one cycle (the core retires the instruction); mem_rd/mem_wr are ignored; go IDLE next cycle.
  - Back-to-back accesses are therefore separated by at least one IDLE decode cycle.
- stall = (IDLE & legal access) | REQ | WAIT_R.
- Minimum latency with gnt and rvalid immediate:
  - Store: stall high 2 cycles.
  - Load: stall high 3 cycles.
- Timeout (TIMEOUT>0):
  - Counter clears on entering REQ and increments each cycle in REQ/WAIT_R.
  - When it equals TIMEOUT without the completing event: bus_req drops; bus_err=1 for the cycle of entry to DONE; rd_data=0 for loads; go DONE.
  - Late gnt/rvalid arriving afterwards is ignored while in DONE/IDLE.
- rd_data holds its last value until the next load completes; stores never change it.
- Reset asserted mid-transaction aborts immediately: bus_req=0, stall=0, no error pulse.

Test Plan:
- LW addr=0x100, bus_rdata=0xDEADBEEF, gnt on the first REQ cycle, rvalid 2 cycles later → bus_addr=0x100, bus_be=1111, bus_we=0, rd_data=0xDEADBEEF, stall high 4 cycles then low 1 cycle (DONE).
- LB addr=0x103, rdata=0x80FF0011 → rd_data=0xFFFFFF80; LBU same → 0x00000080; LHU addr=0x102 → 0x000080FF.
- SH addr=0x206, wr_data=0x1234ABCD, gnt immediate → bus_addr=0x204, bus_be=1100, bus_wdata=0xABCDABCD, bus_we=1, stall high 2 cycles, rd_data unchanged.
- LW addr=0x1002 → access_err pulse 1 cycle, bus_req never asserted, stall=0; same result for funct3=011.
- TIMEOUT=4, LW with gnt never asserted → bus_req high 4 cycles, then bus_err pulse, rd_data=0, stall released; a late gnt 2 cycles later causes no state change.
- Reset pulse while in WAIT_R → bus_req=0, stall=0, rd_data=0 asynchronously; the next LW after reset completes normally.
